// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, RV32I base
// opcodes, immediate formats, ALU operations and write-back selects.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I     = 3'd0;
  localparam logic [2:0] IMM_SHAMT = 3'd1;
  localparam logic [2:0] IMM_S     = 3'd2;
  localparam logic [2:0] IMM_B     = 3'd3;
  localparam logic [2:0] IMM_U     = 3'd4;
  localparam logic [2:0] IMM_J     = 3'd5;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  function automatic logic opc_supported(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_sel_of(input logic [6:0] opc, input logic [2:0] func3);
    case (opc)
      OPC_OPIMM:            return (func3 == 3'b001 || func3 == 3'b101) ? IMM_SHAMT : IMM_I;
      OPC_STORE:            return IMM_S;
      OPC_BRANCH:           return IMM_B;
      OPC_LUI, OPC_AUIPC:   return IMM_U;
      OPC_JAL:              return IMM_J;
      default:              return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decode.sv
// Combinational ALU-control decode from opcode/func3/func7[5].
// Branches select the compare op whose result feeds branch_taken.
module alu_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opc,
  input  logic [2:0] func3,
  input  logic       func7_b5,
  output logic [3:0] alu_op,
  output logic       alu_src_b
);

  always_comb begin
    alu_op    = ALU_ADD;
    alu_src_b = 1'b0;
    case (opc)
      OPC_OP, OPC_OPIMM: begin
        alu_src_b = (opc == OPC_OPIMM);
        case (func3)
          3'b000:  alu_op = (opc == OPC_OP && func7_b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = func7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      OPC_BRANCH: begin
        // BEQ/BNE compare by subtraction; BLT/BGE and BLTU/BGEU by set-less-than
        case (func3[2:1])
          2'b10:   alu_op = ALU_SLT;
          2'b11:   alu_op = ALU_SLTU;
          default: alu_op = ALU_SUB;
        endcase
      end
      OPC_LUI: begin
        alu_op    = ALU_PASS_B;
        alu_src_b = 1'b1;
      end
      OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR: begin
        alu_op    = ALU_ADD;
        alu_src_b = 1'b1;
      end
      default: begin
        alu_op    = ALU_ADD;
        alu_src_b = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with a memory-wait
// timeout that parks the core in a sticky TRAP until reset.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] OPC,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       branch_taken,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       fetch,
  output logic       imm_extend_WE,
  output logic [2:0] imm_SEL,
  output logic [3:0] alu_op,
  output logic       alu_src_b,
  output logic       reg_WE,
  output logic [1:0] wb_sel,
  output logic       pc_WE,
  output logic       pc_src,
  output logic       retire,
  output logic       trap
);

  localparam int CNT_BITS = $clog2(MEM_TIMEOUT + 1);
  localparam int CNT_W    = (CNT_BITS > 4) ? CNT_BITS : 4;
  localparam logic [CNT_W-1:0] CNT_TO = CNT_W'(MEM_TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  logic       is_load, is_store, is_branch, is_jump, supported;
  logic [3:0] dec_alu_op;
  logic       dec_src_b;
  logic       unused_func7;

  assign is_load      = (OPC == OPC_LOAD);
  assign is_store     = (OPC == OPC_STORE);
  assign is_branch    = (OPC == OPC_BRANCH);
  assign is_jump      = (OPC == OPC_JAL) || (OPC == OPC_JALR);
  assign supported    = opc_supported(OPC);
  assign unused_func7 = ^{func7[6], func7[4:0]};

  alu_decode u_alu_decode (
    .opc       (OPC),
    .func3     (func3),
    .func7_b5  (func7[5]),
    .alu_op    (dec_alu_op),
    .alu_src_b (dec_src_b)
  );

  // The wait counter clears on every transition and only advances while a
  // FETCH/MEM state waits; an ack on the timeout cycle still wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_FETCH: begin
          if (imem_ack)               state <= S_DECODE;
          else if (wait_cnt == CNT_TO) state <= S_TRAP;
          else                        wait_cnt <= wait_cnt + 1'b1;
        end
        S_DECODE: state <= supported ? S_EXEC : S_TRAP;
        S_EXEC: begin
          if (is_branch)                 state <= S_FETCH;
          else if (is_load || is_store)  state <= S_MEM;
          else                           state <= S_WB;
        end
        S_MEM: begin
          if (dmem_ack)               state <= is_store ? S_FETCH : S_WB;
          else if (wait_cnt == CNT_TO) state <= S_TRAP;
          else                        wait_cnt <= wait_cnt + 1'b1;
        end
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    fetch         = 1'b0;
    imm_extend_WE = 1'b0;
    imm_SEL       = IMM_I;
    alu_op        = ALU_ADD;
    alu_src_b     = 1'b0;
    reg_WE        = 1'b0;
    wb_sel        = WB_ALU;
    pc_WE         = 1'b0;
    pc_src        = 1'b0;
    retire        = 1'b0;
    trap          = 1'b0;
    // Reset masks every strobe, including a half-finished MEM access.
    if (!rst) begin
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          fetch    = imem_ack;
        end
        S_DECODE: begin
          if (supported) begin
            imm_extend_WE = 1'b1;
            imm_SEL       = imm_sel_of(OPC, func3);
          end
        end
        S_EXEC: begin
          alu_op    = dec_alu_op;
          alu_src_b = dec_src_b;
          if (is_branch) begin
            pc_WE  = 1'b1;
            pc_src = branch_taken;
            retire = 1'b1;
          end
        end
        S_MEM: begin
          alu_op    = dec_alu_op;
          alu_src_b = dec_src_b;
          dmem_req  = 1'b1;
          dmem_we   = is_store;
          if (dmem_ack && is_store) begin
            pc_WE  = 1'b1;
            retire = 1'b1;
          end
        end
        S_WB: begin
          alu_op    = dec_alu_op;
          alu_src_b = dec_src_b;
          reg_WE    = 1'b1;
          pc_WE     = 1'b1;
          retire    = 1'b1;
          if (is_jump) begin
            wb_sel = WB_PC4;
            pc_src = 1'b1;
          end else if (is_load) begin
            wb_sel = WB_LOAD;
          end
        end
        S_TRAP:  trap = 1'b1;
        default: trap = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Random and directed instruction streams checked cycle by cycle against an
// instruction-level trace model, plus literal latency/select expectations.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] OPC = '0;
  logic [2:0] func3 = '0;
  logic [6:0] func7 = '0;
  logic branch_taken = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic imem_req, dmem_req, dmem_we, fetch, imm_extend_WE;
  logic [2:0] imm_SEL;
  logic [3:0] alu_op;
  logic alu_src_b, reg_WE;
  logic [1:0] wb_sel;
  logic pc_WE, pc_src, retire, trap;

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .OPC(OPC), .func3(func3), .func7(func7),
    .branch_taken(branch_taken), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .fetch(fetch),
    .imm_extend_WE(imm_extend_WE), .imm_SEL(imm_SEL), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .reg_WE(reg_WE), .wb_sel(wb_sel), .pc_WE(pc_WE),
    .pc_src(pc_src), .retire(retire), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req, dmem_req, dmem_we, fetch, imm_we;
    logic [2:0] imm_sel;
    logic [3:0] alu_op;
    logic       alu_src_b, reg_we;
    logic [1:0] wb_sel;
    logic       pc_we, pc_src, retire, trap;
  } obs_t;

  localparam logic [3:0] RR_OP [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                       ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  localparam logic [6:0] SUP [9] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                     OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};

  obs_t act;
  obs_t exp_q[$];
  assign act = {imem_req, dmem_req, dmem_we, fetch, imm_extend_WE, imm_SEL, alu_op,
                alu_src_b, reg_WE, wb_sel, pc_WE, pc_src, retire, trap};

  int checks = 0, failures = 0, cyc = 0;
  int dmem_req_seen = 0, retire_seen = 0, retire_exp = 0, trap_seen = 0;
  int last_fetch = -1, last_retire = -1, last_imm_sel = -1, last_wb_sel = -1, last_pc_src = -1;
  logic [6:0] cur_opc = '0, cur_f7 = '0;
  logic [2:0] cur_f3 = '0;

  always @(negedge clk) begin : compare
    obs_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL outputs cyc=%0d opc=%b got=%h want=%h", cyc, OPC, act, e);
      end
      checks++;
      if ($countones({fetch, imm_extend_WE, reg_WE, dmem_req}) > 1) begin
        failures++;
        $display("FAIL exclusive_strobes cyc=%0d got=%b want=at_most_one", cyc,
                 {fetch, imm_extend_WE, reg_WE, dmem_req});
      end
    end
    if (dmem_req === 1'b1) dmem_req_seen++;
    if (trap === 1'b1) trap_seen++;
    if (fetch === 1'b1) last_fetch = cyc;
    if (retire === 1'b1) begin retire_seen++; last_retire = cyc; end
    if (imm_extend_WE === 1'b1) last_imm_sel = int'(imm_SEL);
    if (reg_WE === 1'b1) last_wb_sel = int'(wb_sel);
    if (pc_WE === 1'b1) last_pc_src = int'(pc_src);
  end

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  function automatic logic m_sup(input logic [6:0] opc);
    foreach (SUP[i]) if (SUP[i] == opc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] m_imm(input logic [6:0] opc, input logic [2:0] f3);
    if (opc == OPC_OPIMM && (f3 == 3'd1 || f3 == 3'd5)) return IMM_SHAMT;
    if (opc == OPC_STORE) return IMM_S;
    if (opc == OPC_BRANCH) return IMM_B;
    if (opc == OPC_LUI || opc == OPC_AUIPC) return IMM_U;
    if (opc == OPC_JAL) return IMM_J;
    return IMM_I;
  endfunction

  // Returns {alu_src_b, alu_op}.
  function automatic logic [4:0] m_alu(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [6:0] f7);
    logic [3:0] op;
    if (opc == OPC_OP || opc == OPC_OPIMM) begin
      op = RR_OP[f3];
      if (f7[5] && f3 == 3'd5) op = ALU_SRA;
      if (f7[5] && f3 == 3'd0 && opc == OPC_OP) op = ALU_SUB;
      return {opc == OPC_OPIMM, op};
    end
    if (opc == OPC_BRANCH) return {1'b0, f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB};
    if (opc == OPC_LUI) return {1'b1, ALU_PASS_B};
    if (m_sup(opc)) return {1'b1, ALU_ADD};
    return 5'd0;
  endfunction

  function automatic int pick_dly();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return TO + 1;
    if (r == 1) return TO;
    return $urandom_range(0, 3);
  endfunction

  task automatic step(input obs_t e, input logic r, input logic ia, input logic da, input logic bt);
    @(posedge clk); #1;
    rst = r; imem_ack = ia; dmem_ack = da; branch_taken = bt;
    OPC = cur_opc; func3 = cur_f3; func7 = cur_f7;
    exp_q.push_back(e);
    if (e.retire) retire_exp++;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic trap_and_reset();
    obs_t e;
    e = '0; e.trap = 1'b1;
    repeat (3) step(e, 1'b0, rnd1(), rnd1(), rnd1());
    e = '0;
    step(e, 1'b1, rnd1(), rnd1(), rnd1());
  endtask

  // One instruction from FETCH: idly/ddly = ack cycle index (beyond TO means none),
  // abort_mem = MEM cycle at which reset is pulsed (-1 none), bt_force -1 = random.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input int idly, input int ddly, input int abort_mem, input int bt_force);
    obs_t e;
    logic ack, bt, dead, is_mem, is_st;
    logic [4:0] a;
    cur_opc = opc; cur_f3 = f3; cur_f7 = f7;
    a = m_alu(opc, f3, f7);
    is_st = (opc == OPC_STORE);
    is_mem = is_st || (opc == OPC_LOAD);
    dead = 1'b0; ack = 1'b0;
    for (int k = 0; k <= TO; k++) begin
      ack = (k == idly);
      e = '0; e.imem_req = 1'b1; e.fetch = ack;
      step(e, 1'b0, ack, rnd1(), rnd1());
      if (ack) break;
    end
    if (!ack) dead = 1'b1;
    if (!dead) begin
      e = '0;
      if (m_sup(opc)) begin e.imm_we = 1'b1; e.imm_sel = m_imm(opc, f3); end
      else dead = 1'b1;
      step(e, 1'b0, rnd1(), rnd1(), rnd1());
    end
    if (!dead) begin
      bt = (bt_force < 0) ? rnd1() : 1'(bt_force);
      e = '0; e.alu_op = a[3:0]; e.alu_src_b = a[4];
      if (opc == OPC_BRANCH) begin e.pc_we = 1'b1; e.pc_src = bt; e.retire = 1'b1; end
      step(e, 1'b0, rnd1(), rnd1(), bt);
    end
    if (!dead && is_mem) begin
      ack = 1'b0;
      for (int k = 0; k <= TO; k++) begin
        if (k == abort_mem) begin
          e = '0;
          step(e, 1'b1, rnd1(), 1'b1, rnd1());
          return;
        end
        ack = (k == ddly);
        e = '0; e.dmem_req = 1'b1; e.dmem_we = is_st; e.alu_op = a[3:0]; e.alu_src_b = a[4];
        if (ack && is_st) begin e.pc_we = 1'b1; e.retire = 1'b1; end
        step(e, 1'b0, rnd1(), ack, rnd1());
        if (ack) break;
      end
      if (!ack) dead = 1'b1;
    end
    if (!dead && opc != OPC_BRANCH && !is_st) begin
      e = '0; e.alu_op = a[3:0]; e.alu_src_b = a[4];
      e.reg_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1;
      if (opc == OPC_JAL || opc == OPC_JALR) begin e.wb_sel = WB_PC4; e.pc_src = 1'b1; end
      else if (opc == OPC_LOAD) e.wb_sel = WB_LOAD;
      step(e, 1'b0, rnd1(), rnd1(), rnd1());
    end
    if (dead) trap_and_reset();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    obs_t z;
    logic [31:0] insn;
    int r0, d0, t0;
    z = '0;
    step(z, 1'b1, 1'b0, 1'b0, 1'b0);
    step(z, 1'b1, 1'b1, 1'b1, 1'b1);

    insn = 32'h00500093;  // addi x1, x0, 5
    r0 = retire_seen;
    run_instr(insn[6:0], insn[14:12], insn[31:25], 0, 0, -1, -1); settle();
    chk("addi_latency", last_retire - last_fetch + 1, 4);
    chk("addi_retire", retire_seen - r0, 1);
    chk("addi_imm_sel", last_imm_sel, 0);
    chk("addi_wb_sel", last_wb_sel, 0);

    insn = 32'h0020a103;  // lw x2, 2(x1)
    d0 = dmem_req_seen;
    run_instr(insn[6:0], insn[14:12], insn[31:25], 0, 3, -1, -1); settle();
    chk("lw_latency", last_retire - last_fetch + 1, 8);
    chk("lw_dmem_req_cycles", dmem_req_seen - d0, 4);
    chk("lw_wb_sel", last_wb_sel, 1);

    insn = 32'h00208463;  // beq x1, x2, 8
    run_instr(insn[6:0], insn[14:12], insn[31:25], 0, 0, -1, 1); settle();
    chk("beq_latency", last_retire - last_fetch + 1, 3);
    chk("beq_imm_sel", last_imm_sel, 3);
    chk("beq_pc_src", last_pc_src, 1);

    insn = 32'h00309093;  // slli x1, x1, 3
    run_instr(insn[6:0], insn[14:12], insn[31:25], 0, 0, -1, -1); settle();
    chk("slli_imm_sel", last_imm_sel, 1);

    insn = 32'h008000ef;  // jal x1, 8
    run_instr(insn[6:0], insn[14:12], insn[31:25], 0, 0, -1, -1); settle();
    chk("jal_imm_sel", last_imm_sel, 5);
    chk("jal_wb_sel", last_wb_sel, 2);
    chk("jal_pc_src", last_pc_src, 1);

    insn = 32'h0020a423;  // sw x2, 8(x1)
    r0 = retire_seen; t0 = trap_seen;
    run_instr(insn[6:0], insn[14:12], insn[31:25], 0, TO + 1, -1, -1); settle();
    chk("sw_timeout_retire", retire_seen - r0, 0);
    chk("sw_timeout_trap_cycles", trap_seen - t0, 3);

    r0 = retire_seen; t0 = trap_seen;
    run_instr(insn[6:0], insn[14:12], insn[31:25], 0, TO, -1, -1); settle();
    chk("sw_ack_on_timeout_latency", last_retire - last_fetch + 1, 3 + TO + 1);
    chk("sw_ack_on_timeout_trap", trap_seen - t0, 0);

    t0 = trap_seen;
    run_instr(7'h13, 3'd0, 7'd0, TO + 1, 0, -1, -1); settle();
    chk("fetch_timeout_trap_cycles", trap_seen - t0, 3);
    run_instr(7'h13, 3'd0, 7'd0, TO, 0, -1, -1); settle();
    chk("fetch_ack_on_timeout_latency", last_retire - last_fetch + 1, 4);

    t0 = trap_seen;
    run_instr(7'b0000000, 3'd0, 7'd0, 0, 0, -1, -1); settle();
    chk("illegal_opc_trap_cycles", trap_seen - t0, 3);

    r0 = retire_seen;
    run_instr(insn[6:0], insn[14:12], insn[31:25], 0, 5, 1, -1);
    run_instr(7'h13, 3'd0, 7'd0, 0, 0, -1, -1); settle();
    chk("sw_abort_then_addi_retire", retire_seen - r0, 1);

    for (int i = 0; i < 300; i++) begin
      logic [6:0] o;
      case ($urandom_range(0, 15))
        0:       o = 7'b0000000;
        1:       o = 7'b1111111;
        default: o = SUP[$urandom_range(0, 8)];
      endcase
      run_instr(o, 3'($urandom), 7'($urandom), pick_dly(), pick_dly(),
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : -1, -1);
    end
    settle();
    chk("retire_total", retire_seen, retire_exp);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
